// File: rtl/data_mem_arbiter_pkg.sv
// mem_arb_pkg: shared types and default widths for the data memory arbiter.
//   owner_t      - which port owns the RAM read data returning this cycle
//   lock_state_t - debug-port exclusive-ownership state
package mem_arb_pkg;

  localparam int DATA_MEM_ADDR_W = 16;
  localparam int DATA_MEM_DATA_W = 18;

  typedef enum logic [1:0] {OWNER_NONE, OWNER_CPU, OWNER_DBG} owner_t;
  typedef enum logic {LOCK_UNLOCKED, LOCK_LOCKED} lock_state_t;

endpackage

// File: rtl/data_mem_arbiter_if.sv
// data_mem_arbiter_if: one requester's access port into the data memory.
//   req/we/addr/wdata - access request, held by the requester until gnt
//   gnt               - access presented to the RAM this cycle
//   rvalid/rdata      - read data, one cycle after a read gnt
// master = requester side, slave = arbiter side.
interface data_mem_arbiter_if
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W = DATA_MEM_ADDR_W,
  parameter int DATA_W = DATA_MEM_DATA_W
) ();

  logic              req;
  logic              we;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic              gnt;
  logic              rvalid;
  logic [DATA_W-1:0] rdata;

  modport master (output req, we, addr, wdata, input gnt, rvalid, rdata);
  modport slave  (input req, we, addr, wdata, output gnt, rvalid, rdata);

endinterface

// File: rtl/data_mem_arbiter_wait_counter.sv
// arb_wait_counter: saturating counter of cycles the debug port has lost.
//   clk_i, rst_i - clock, synchronous active-high reset
//   inc_i        - count one lost cycle (saturates at MAX)
//   clr_i        - clear (wins over inc_i)
//   at_max_o     - count has reached MAX
module arb_wait_counter #(
  parameter int MAX = 8,
  parameter int W   = 8
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic inc_i,
  input  logic clr_i,
  output logic at_max_o
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i)                          cnt_d = '0;
    else if (inc_i && cnt_q != W'(MAX)) cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign at_max_o = (cnt_q == W'(MAX));

endmodule

// File: rtl/data_mem_arbiter.sv
// data_mem_arbiter: shares the single-port data RAM between the CPU data
// port (fixed priority) and the UART debug port (starvation-protected, with
// an exclusive lock for multi-word transfers).
//   clk_50M, reset      - clock, synchronous active-high reset
//   cpu, dbg            - requester ports (slave side)
//   dbg_lock            - debug port asks for exclusive ownership
//   dbg_lock_ack        - exclusive ownership held (registered)
//   data_address/write/wren, data_read - RAM pins; read data lags by 1 cycle
module data_mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W   = DATA_MEM_ADDR_W,
  parameter int DATA_W   = DATA_MEM_DATA_W,
  parameter int MAX_WAIT = 8
) (
  input  logic              clk_50M,
  input  logic              reset,
  data_mem_arbiter_if.slave cpu,
  data_mem_arbiter_if.slave dbg,
  input  logic              dbg_lock,
  output logic              dbg_lock_ack,
  output logic [ADDR_W-1:0] data_address,
  input  logic [DATA_W-1:0] data_read,
  output logic [DATA_W-1:0] data_write,
  output logic              data_wren
);

  lock_state_t       lock_q, lock_d;
  owner_t            rd_owner_q, rd_owner_d;
  logic [ADDR_W-1:0] addr_q;
  logic              locked, wait_at_max;
  logic              cpu_win, dbg_win;

  assign locked = (lock_q == LOCK_LOCKED);

  // Winner selection. Lock or a starved debug request overrides CPU
  // priority; in lock with no debug request nobody is granted.
  always_comb begin
    cpu_win = 1'b0;
    dbg_win = 1'b0;
    if (!reset) begin
      if (locked || (dbg.req && wait_at_max)) dbg_win = dbg.req;
      else if (cpu.req)                       cpu_win = 1'b1;
      else                                    dbg_win = dbg.req;
    end
  end

  assign cpu.gnt = cpu_win;
  assign dbg.gnt = dbg_win;

  // RAM pin mux; the address is parked on the last granted access.
  always_comb begin
    data_address = addr_q;
    data_write   = cpu.wdata;
    data_wren    = 1'b0;
    if (dbg_win) begin
      data_address = dbg.addr;
      data_write   = dbg.wdata;
      data_wren    = dbg.we;
    end else if (cpu_win) begin
      data_address = cpu.addr;
      data_write   = cpu.wdata;
      data_wren    = cpu.we;
    end
  end

  always_comb begin
    rd_owner_d = OWNER_NONE;
    if (dbg_win && !dbg.we)      rd_owner_d = OWNER_DBG;
    else if (cpu_win && !cpu.we) rd_owner_d = OWNER_CPU;
  end

  // Lock FSM next state
  always_comb begin
    lock_d = lock_q;
    case (lock_q)
      LOCK_UNLOCKED: if (dbg_lock)  lock_d = LOCK_LOCKED;
      LOCK_LOCKED:   if (!dbg_lock) lock_d = LOCK_UNLOCKED;
      default:                      lock_d = LOCK_UNLOCKED;
    endcase
  end

  always_ff @(posedge clk_50M) begin
    if (reset) begin
      lock_q     <= LOCK_UNLOCKED;
      rd_owner_q <= OWNER_NONE;
      addr_q     <= '0;
    end else begin
      lock_q     <= lock_d;
      rd_owner_q <= rd_owner_d;
      addr_q     <= data_address;
    end
  end

  assign dbg_lock_ack = locked;

  // rvalid is gated by reset so a read granted just before reset is dropped.
  assign cpu.rvalid = !reset && (rd_owner_q == OWNER_CPU);
  assign dbg.rvalid = !reset && (rd_owner_q == OWNER_DBG);
  assign cpu.rdata  = data_read;
  assign dbg.rdata  = data_read;

  arb_wait_counter #(.MAX(MAX_WAIT), .W(8)) u_wait (
    .clk_i    (clk_50M),
    .rst_i    (reset),
    .inc_i    (dbg.req && !dbg_win),
    .clr_i    (dbg_win || !dbg.req),
    .at_max_o (wait_at_max)
  );

endmodule

// File: tb/tb_data_mem_arbiter.sv
// tb_data_mem_arbiter: directed plus randomized checks of data_mem_arbiter
// against a cycle-level model of the arbitration rules and a shadow memory.
module tb_data_mem_arbiter;
  import mem_arb_pkg::*;

  localparam int AW = 16;
  localparam int DW = 18;
  localparam int MW = 8;

  logic clk_50M = 1'b0;
  logic reset;
  logic dbg_lock, dbg_lock_ack, data_wren;
  logic [AW-1:0] data_address;
  logic [DW-1:0] data_read, data_write;

  always #10 clk_50M = ~clk_50M;

  data_mem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) cpu_if ();
  data_mem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) dbg_if ();

  data_mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MAX_WAIT(MW)) dut (
    .clk_50M      (clk_50M),
    .reset        (reset),
    .cpu          (cpu_if),
    .dbg          (dbg_if),
    .dbg_lock     (dbg_lock),
    .dbg_lock_ack (dbg_lock_ack),
    .data_address (data_address),
    .data_read    (data_read),
    .data_write   (data_write),
    .data_wren    (data_wren)
  );

  // RAM image driven by the DUT pins, and an independent shadow of what
  // memory should contain according to the expected grants.
  logic [DW-1:0] ram    [0:65535];
  logic [DW-1:0] shadow [0:65535];

  int            n_chk = 0;
  int            n_pass = 0;
  int            lost;
  logic          m_locked;
  int            rd_pend;
  logic [DW-1:0] rd_exp;
  logic [AW-1:0] m_last;
  logic          last_ec, last_ed;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // One clock cycle: check at negedge against the model, then advance the
  // RAM image and the model at the posedge.
  task automatic step();
    logic ec, ed, ewe, xwren, rst_s, lock_s, dreq_s, s_wren;
    logic [AW-1:0] eaddr, s_addr;
    logic [DW-1:0] ewd, nexp, s_wd;
    int npend;
    @(negedge clk_50M);
    rst_s = reset; lock_s = dbg_lock; dreq_s = dbg_if.req;
    ec = 1'b0; ed = 1'b0;
    if (!rst_s) begin
      ed = dbg_if.req && (m_locked || lost == MW || !cpu_if.req);
      ec = cpu_if.req && !m_locked && !(dbg_if.req && lost == MW);
    end
    ewe = 1'b0; eaddr = m_last; ewd = '0;
    if (ed) begin
      ewe = dbg_if.we; eaddr = dbg_if.addr; ewd = dbg_if.wdata;
    end else if (ec) begin
      ewe = cpu_if.we; eaddr = cpu_if.addr; ewd = cpu_if.wdata;
    end
    xwren = (ec || ed) && ewe;
    npend = 0; nexp = '0;
    if ((ec || ed) && !ewe) begin
      npend = ed ? 2 : 1;
      nexp  = shadow[eaddr];
    end
    chk("cpu_gnt", 32'(cpu_if.gnt), 32'(ec));
    chk("dbg_gnt", 32'(dbg_if.gnt), 32'(ed));
    chk("cpu_rvalid", 32'(cpu_if.rvalid), 32'(!rst_s && rd_pend == 1));
    chk("dbg_rvalid", 32'(dbg_if.rvalid), 32'(!rst_s && rd_pend == 2));
    if (!rst_s && rd_pend == 1) chk("cpu_rdata", 32'(cpu_if.rdata), 32'(rd_exp));
    if (!rst_s && rd_pend == 2) chk("dbg_rdata", 32'(dbg_if.rdata), 32'(rd_exp));
    chk("data_wren", 32'(data_wren), 32'(xwren));
    if (!rst_s) chk("data_address", 32'(data_address), 32'(eaddr));
    if (xwren) chk("data_write", 32'(data_write), 32'(ewd));
    chk("dbg_lock_ack", 32'(dbg_lock_ack), 32'(m_locked));
    s_wren = data_wren; s_addr = data_address; s_wd = data_write;
    last_ec = ec; last_ed = ed;
    @(posedge clk_50M);
    if (s_wren === 1'b1) begin
      ram[s_addr] = s_wd; data_read = s_wd;
    end else begin
      data_read = ram[s_addr];
    end
    if (rst_s) begin
      lost = 0; m_locked = 1'b0; rd_pend = 0; m_last = '0;
    end else begin
      if (xwren) shadow[eaddr] = ewd;
      lost     = (dreq_s && !ed) ? ((lost < MW) ? lost + 1 : MW) : 0;
      m_locked = lock_s;
      rd_pend  = npend;
      rd_exp   = nexp;
      m_last   = eaddr;
    end
    #1;
  endtask

  task automatic drive(input logic creq, input logic cwe, input logic [AW-1:0] caddr,
                       input logic dreq, input logic dwe, input logic [AW-1:0] daddr,
                       input logic [DW-1:0] dwd);
    cpu_if.req = creq; cpu_if.we = cwe; cpu_if.addr = caddr; cpu_if.wdata = 18'h0_1234;
    dbg_if.req = dreq; dbg_if.we = dwe; dbg_if.addr = daddr; dbg_if.wdata = dwd;
  endtask

  initial begin
    logic cpend, dpend;
    int   lock_left;
    for (int i = 0; i < 65536; i++) begin
      ram[i]    = DW'(i * 37 + 5) ^ 18'h15A5A;
      shadow[i] = ram[i];
    end
    ram[16] = 18'h2ABCD; shadow[16] = 18'h2ABCD;
    data_read = '0;
    lost = 0; m_locked = 1'b0; rd_pend = 0; rd_exp = '0; m_last = '0;
    last_ec = 1'b0; last_ed = 1'b0;
    reset = 1'b1; dbg_lock = 1'b0;

    // Reset with write requests pending: nothing may reach the RAM.
    drive(1'b1, 1'b1, 16'h0005, 1'b1, 1'b1, 16'h0006, 18'h11111);
    repeat (3) step();

    // CPU read of 0x0010
    reset = 1'b0;
    drive(1'b1, 1'b0, 16'h0010, 1'b0, 1'b0, 16'h0000, '0);
    #2 chk("t1_cpu_gnt", 32'(cpu_if.gnt), 32'd1);
    step();
    drive(1'b0, 1'b0, 16'h0010, 1'b0, 1'b0, 16'h0000, '0);
    #2;
    chk("t1_cpu_rvalid", 32'(cpu_if.rvalid), 32'd1);
    chk("t1_cpu_rdata", 32'(cpu_if.rdata), 32'h2ABCD);
    chk("t1_dbg_rvalid", 32'(dbg_if.rvalid), 32'd0);
    step();

    // Both ports hammering: period-9 pattern, debug gets every 9th slot.
    drive(1'b1, 1'b0, 16'h0020, 1'b1, 1'b0, 16'h0030, '0);
    for (int c = 0; c < 27; c++) begin
      #2;
      chk("t2_dbg_slot", 32'(dbg_if.gnt), 32'(c % 9 == 8));
      chk("t2_cpu_slot", 32'(cpu_if.gnt), 32'(c % 9 != 8));
      step();
    end

    // Lock while the CPU keeps requesting.
    drive(1'b1, 1'b0, 16'h0040, 1'b0, 1'b0, 16'h0000, '0);
    dbg_lock = 1'b1;
    #2 chk("t3_ack_pre", 32'(dbg_lock_ack), 32'd0);
    step();
    for (int i = 0; i < 20; i++) begin
      drive(1'b1, 1'b0, 16'h0040, 1'b1, 1'b0, AW'(16'h0100 + i), '0);
      #2;
      chk("t3_ack", 32'(dbg_lock_ack), 32'd1);
      chk("t3_cpu_held", 32'(cpu_if.gnt), 32'd0);
      chk("t3_dbg_gnt", 32'(dbg_if.gnt), 32'd1);
      step();
    end
    drive(1'b1, 1'b0, 16'h0040, 1'b0, 1'b0, 16'h0000, '0);
    dbg_lock = 1'b0;
    #2 chk("t3_cpu_held_drop", 32'(cpu_if.gnt), 32'd0);
    step();
    #2;
    chk("t3_ack_fell", 32'(dbg_lock_ack), 32'd0);
    chk("t3_cpu_resume", 32'(cpu_if.gnt), 32'd1);
    step();

    // Debug write to top word, CPU reads it back next cycle.
    drive(1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, 16'hFFFF, 18'h3FFFF);
    #2;
    chk("t4_dbg_gnt", 32'(dbg_if.gnt), 32'd1);
    chk("t4_wren", 32'(data_wren), 32'd1);
    step();
    drive(1'b1, 1'b0, 16'hFFFF, 1'b0, 1'b0, 16'h0000, '0);
    #2 chk("t4_wren_once", 32'(data_wren), 32'd0);
    step();
    drive(1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, '0);
    #2 chk("t4_cpu_rdata", 32'(cpu_if.rdata), 32'h3FFFF);
    step();

    // Build up wait count and a lock, grant a CPU read, then reset.
    drive(1'b1, 1'b0, 16'h0050, 1'b1, 1'b0, 16'h0060, '0);
    repeat (4) step();
    drive(1'b1, 1'b0, 16'h0010, 1'b1, 1'b0, 16'h0060, '0);
    dbg_lock = 1'b1;
    #2 chk("t5_cpu_gnt", 32'(cpu_if.gnt), 32'd1);
    step();
    reset = 1'b1;
    drive(1'b1, 1'b1, 16'h0010, 1'b1, 1'b1, 16'h0060, 18'h22222);
    #2;
    chk("t5_no_rvalid", 32'(cpu_if.rvalid), 32'd0);
    chk("t5_wren_rst", 32'(data_wren), 32'd0);
    step();
    dbg_lock = 1'b0;
    repeat (2) begin
      #2 chk("t5_wren_rst", 32'(data_wren), 32'd0);
      step();
    end
    reset = 1'b0;
    drive(1'b1, 1'b0, 16'h0070, 1'b1, 1'b0, 16'h0080, '0);
    #2 chk("t5_ack_rel", 32'(dbg_lock_ack), 32'd0);
    for (int c = 0; c < 9; c++) begin
      #2 chk("t5_wait_cleared", 32'(dbg_if.gnt), 32'(c == 8));
      step();
    end

    // Randomized traffic with requests held until granted and random locks.
    drive(1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, '0);
    step();
    cpend = 1'b0; dpend = 1'b0; lock_left = 0;
    for (int c = 0; c < 400; c++) begin
      if (cpend && last_ec) cpend = 1'b0;
      if (dpend && last_ed) dpend = 1'b0;
      if (!cpend && $urandom_range(9, 0) < 6) begin
        cpend = 1'b1;
        cpu_if.we    = $urandom_range(1, 0) == 1;
        cpu_if.addr  = AW'($urandom_range(31, 0));
        cpu_if.wdata = DW'($urandom);
      end
      if (!dpend && $urandom_range(9, 0) < 5) begin
        dpend = 1'b1;
        dbg_if.we    = $urandom_range(1, 0) == 1;
        dbg_if.addr  = AW'($urandom_range(31, 0));
        dbg_if.wdata = DW'($urandom);
      end
      cpu_if.req = cpend;
      dbg_if.req = dpend;
      if (lock_left > 0) lock_left--;
      else if ($urandom_range(39, 0) == 0) lock_left = $urandom_range(12, 3);
      dbg_lock = (lock_left > 0);
      step();
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/data_mem_arbiter.md
# data_mem_arbiter

Shares the single-port 18-bit data memory between two requesters: the asm18 CPU data port and the UART debug controller. The CPU has fixed priority. A starvation counter guarantees the debug port forward progress. A lock handshake gives the debug port exclusive ownership for multi-word dumps and loads. The block sits between both requesters and the data RAM, and is the only driver of the RAM's address, write-data and write-enable pins.

## Interface
- ADDR_W, 16, memory word address width
- DATA_W, 18, memory word width
- MAX_WAIT, 8, cycles a pending debug request may lose to the CPU before it is forced through (1..255)

- clk_50M  in  1  system clock
- reset  in  1  synchronous, active-high reset
- cpu_req  in  1  CPU access request, held until granted
- cpu_we  in  1  1 = write, 0 = read
- cpu_addr  in  ADDR_W  CPU word address
- cpu_wdata  in  DATA_W  CPU write data
- cpu_gnt  out  1  access issued to RAM this cycle
- cpu_rvalid  out  1  read data valid (one cycle after a read grant)
- cpu_rdata  out  DATA_W  read data
- dbg_req, dbg_we, dbg_addr, dbg_wdata, dbg_gnt, dbg_rvalid, dbg_rdata  as the cpu_* set, for the debug port
- dbg_lock  in  1  request exclusive ownership
- dbg_lock_ack  out  1  exclusive ownership held
- data_address  out  ADDR_W  RAM address
- data_read  in  DATA_W  RAM read data, valid one cycle after the address is presented
- data_write  out  DATA_W  RAM write data
- data_wren  out  1  RAM write strobe

## Operation
**Arbitration.** The winner is chosen combinationally each cycle:
- dbg wins if lock_state = LOCKED, or if dbg_req && wait_cnt == MAX_WAIT.
- Otherwise cpu wins if cpu_req, then dbg if dbg_req, else no owner.
- In LOCKED, cpu_gnt is forced to 0 and cpu_req is simply held off. No error is raised.

**RAM pins.**
- data_address, data_write and data_wren are muxed from the winner.
- data_wren = winner_we && winner_valid.
- With no owner: data_address keeps the last winner's address and data_wren = 0.

**Grant.** x_gnt is asserted in the same cycle its access is presented to the RAM. The requester may change its request fields on the following cycle.

**Read return.**
- Registered owner tag rd_owner ∈ {NONE, CPU, DBG}. It is set on a read grant and is NONE otherwise.
- x_rvalid = (rd_owner == x).
- Both x_rdata outputs are driven directly from data_read.

**Starvation counter wait_cnt (8 bit).**
- Increments when dbg_req && !dbg_gnt, saturating at MAX_WAIT.
- Clears on dbg_gnt or !dbg_req.

**Lock FSM.**
- UNLOCKED → LOCKED when dbg_lock = 1. dbg_lock_ack is registered and rises on the following cycle.
- LOCKED → UNLOCKED when dbg_lock = 0. dbg_lock_ack falls on the following cycle.
- The dbg port may issue accesses before the ack, under normal arbitration.
- Exclusivity starts in the first cycle in which dbg_lock_ack = 1.

**Reset.**
- rd_owner = NONE, wait_cnt = 0, lock_state = UNLOCKED, dbg_lock_ack = 0.
- While reset is high, all gnt and rvalid outputs are 0 and data_wren = 0.
- A read granted in the cycle before reset asserts produces no rvalid.

## Timing
- Grant latency: 0 cycles from req when the port wins.
- Read data latency: 1 cycle after gnt.
- Write: committed at the clock edge of the gnt cycle.
- Throughput: one access per cycle, with back-to-back grants to the same or alternating ports.
- Read-after-write to the same address on consecutive cycles returns the new data. The RAM is write-first, or the ports are disjoint in time.
- Simultaneous cpu_req and dbg_req with wait_cnt < MAX_WAIT: cpu granted, wait_cnt + 1.
- With wait_cnt == MAX_WAIT: dbg granted, wait_cnt → 0, cpu stalls one cycle.
- Worst-case dbg wait: MAX_WAIT cycles. Worst-case cpu wait: 1 cycle, unlocked.
- dbg_lock and dbg_req rising together: the access may be granted that cycle. Lock exclusivity begins the next cycle.

## Structure
- Package mem_arb_pkg holds:
  - typedef enum owner_t {OWNER_NONE, OWNER_CPU, OWNER_DBG}
  - typedef enum lock_state_t {LOCK_UNLOCKED, LOCK_LOCKED}
  - localparams DATA_MEM_ADDR_W = 16 and DATA_MEM_DATA_W = 18
- One sub-module, arb_wait_counter: a saturating counter with inc/clr inputs, parameter MAX, output at_max.
- Everything else is flat in data_mem_arbiter.

## Test plan
- cpu_req read at 0x0010 (RAM holds 0x2ABCD) → cpu_gnt in the same cycle; cpu_rvalid = 1 and cpu_rdata = 0x2ABCD next cycle; dbg_rvalid = 0.
- cpu_req and dbg_req held high continuously, MAX_WAIT = 8 → cpu granted 8 cycles, dbg granted on the 9th, pattern repeats with period 9.
- dbg_lock raised while cpu_req is held → dbg_lock_ack = 1 next cycle; from then cpu_gnt = 0 for 20 cycles while dbg reads 0x0100..0x0113 back-to-back. Drop dbg_lock → cpu_gnt resumes in the cycle after ack falls.
- dbg write 0x3FFFF to 0xFFFF, then cpu read 0xFFFF on the next cycle → data_wren pulses once; cpu_rdata = 0x3FFFF.
- cpu read granted, reset asserted on the next edge → no cpu_rvalid; data_wren = 0 throughout reset; wait_cnt = 0 and dbg_lock_ack = 0 after release.
